// File: rtl/poly_mult_pkg.sv
// Shared constants, FSM encoding and latency helper for the NewHope pointwise multiplier sequencer.
package poly_mult_pkg;

   localparam int unsigned Q              = 12289;
   localparam int unsigned MONT_R         = 3186;
   localparam int unsigned N_DEF          = 1024;
   localparam int unsigned LOG_N          = $clog2(N_DEF);
   localparam int unsigned RD_LAT_DEF     = 1;
   localparam int unsigned DP_LAT_PRE_DEF = 3;
   localparam int unsigned DP_LAT_MUL_DEF = 6;
   localparam int unsigned DL_DEPTH_DEF   = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_e;

   // Read-to-write-back distance L for the selected datapath mode.
   function automatic int unsigned lat_total(
      input logic        mode,
      input int unsigned rd_lat  = RD_LAT_DEF,
      input int unsigned lat_pre = DP_LAT_PRE_DEF,
      input int unsigned lat_mul = DP_LAT_MUL_DEF
   );
      return rd_lat + (mode ? lat_pre : lat_mul);
   endfunction

endpackage

// File: rtl/poly_mult_ctrl_delay_line.sv
// Valid/address shift line with a runtime tap; 'empty' means nothing is still travelling towards the tap.
module ctrl_delay_line #(
   parameter int unsigned DEPTH = 15,
   parameter int unsigned W     = 11,
   parameter int unsigned TAP_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [W-1:0]     din,
   input  logic [TAP_W-1:0] tap,
   output logic [W-1:0]     dout,
   output logic             empty
);

   logic [W-1:0]     stage_q [DEPTH];
   logic [DEPTH-1:0] pend_vec;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else if (clr) begin
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
         stage_q[0] <= din;
         for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
   end

   // Stage k is seen at the output when tap == k+1; stages below the tap still owe a write.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_pend
         assign pend_vec[gi] = stage_q[gi][W-1] && (TAP_W'(gi + 1) < tap);
      end
   endgenerate

   assign empty = !(|pend_vec) && !din[W-1];

   always_comb begin
      dout = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (TAP_W'(k + 1) == tap) dout = stage_q[k];
      end
   end

endmodule

// File: rtl/poly_mult_ctrl.sv
// Sequencer for the pointwise Montgomery multiplier: read walk, datapath enable, aligned write-back.
// Optional cycle counter output enabled by POLY_MULT_CTRL_PERF_EN.
module poly_mult_ctrl
   import poly_mult_pkg::*;
#(
   parameter int unsigned N          = N_DEF,
   parameter int unsigned ADDR_W     = LOG_N,
   parameter int unsigned RD_LAT     = RD_LAT_DEF,
   parameter int unsigned DP_LAT_PRE = DP_LAT_PRE_DEF,
   parameter int unsigned DP_LAT_MUL = DP_LAT_MUL_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              precomp,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              dp_en,
   output logic              dp_precomp,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
`ifdef POLY_MULT_CTRL_PERF_EN
   ,
   output logic [15:0]       cycles
`endif
);

   localparam int unsigned L_PRE    = lat_total(1'b1, RD_LAT, DP_LAT_PRE, DP_LAT_MUL);
   localparam int unsigned L_MUL    = lat_total(1'b0, RD_LAT, DP_LAT_PRE, DP_LAT_MUL);
   localparam int unsigned DL_DEPTH = (L_PRE > L_MUL) ? L_PRE : L_MUL;
   localparam int unsigned TAP_W    = $clog2(DL_DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                mode_q, mode_d;
   logic                accept;
   logic                dl_empty;
   logic [ADDR_W:0]     dl_out;
   logic [TAP_W-1:0]    tap_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      accept  = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      rd_en   = 1'b0;
      dp_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               mode_d  = precomp;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            busy  = 1'b1;
            dp_en = 1'b1;
            rd_en = 1'b1;
            // Counter parks at the last address rather than wrapping.
            if (cnt_q == LAST_ADDR) state_d = DRAIN;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         DRAIN: begin
            busy  = 1'b1;
            dp_en = 1'b1;
            if (dl_empty) state_d = FIN;
         end
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign rd_addr    = cnt_q;
   assign dp_precomp = mode_q;
   assign tap_sel    = mode_q ? TAP_W'(L_PRE) : TAP_W'(L_MUL);

   // Cleared on accept so leftovers past an earlier, shorter tap never reach a longer one.
   ctrl_delay_line #(
      .DEPTH (DL_DEPTH),
      .W     (ADDR_W + 1),
      .TAP_W (TAP_W)
   ) u_delay (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .din   ({rd_en, rd_addr}),
      .tap   (tap_sel),
      .dout  (dl_out),
      .empty (dl_empty)
   );

   assign wr_en   = dl_out[ADDR_W];
   assign wr_addr = dl_out[ADDR_W-1:0];

`ifdef POLY_MULT_CTRL_PERF_EN
   logic [15:0] cyc_q, cyc_d;

   always_comb begin
      cyc_d = cyc_q;
      if (accept)                       cyc_d = '0;
      else if (busy && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cyc_q <= '0;
      else     cyc_q <= cyc_d;
   end

   assign cycles = cyc_q;
`endif

endmodule
